// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between execute (port 0) and the aux sequencer
// (port 1); buffers one response per port and owns the NZCV status register.
module alu_share_ctrl #(
  parameter bit         RR_EN      = 1'b1,
  parameter logic [3:0] STATUS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_val1,
  input  logic [31:0] req0_val2,
  input  logic [3:0]  req0_cmd,
  input  logic        req0_s,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_val1,
  input  logic [31:0] req1_val2,
  input  logic [3:0]  req1_cmd,
  input  logic        req1_s,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_res,
  output logic [3:0]  rsp0_status,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_res,
  output logic [3:0]  rsp1_status,

  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic [3:0]  alu_cmd,
  output logic        alu_carry_in,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_status,

  output logic [3:0]  status_reg
);

  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_res_q, rsp0_res_d;
  logic [31:0] rsp1_res_q, rsp1_res_d;
  logic [3:0]  rsp0_sts_q, rsp0_sts_d;
  logic [3:0]  rsp1_sts_q, rsp1_sts_d;
  logic [3:0]  status_q, status_d;
  logic        rr_ptr_q, rr_ptr_d;

  logic        gnt_en;
  logic        elig0;
  logic        elig1;
  logic        both;
  logic        gnt0;
  logic        gnt1;

  // a port may issue when its buffer is empty or drains on this edge
  always_comb begin
    gnt_en = rst_n & ~flush;
    elig0  = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1  = req1_valid & (~rsp1_valid_q | rsp1_ready);
    both   = elig0 & elig1;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    unique case (1'b1)
      ~gnt_en: begin
      end
      gnt_en & both: begin
        gnt0 = ~RR_EN | ~rr_ptr_q;
        gnt1 = ~gnt0;
      end
      gnt_en & elig0 & ~elig1: begin
        gnt0 = 1'b1;
      end
      gnt_en & elig1 & ~elig0: begin
        gnt1 = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    alu_val1 = req0_val1;
    alu_val2 = req0_val2;
    alu_cmd  = req0_cmd;
    if (gnt1) begin
      alu_val1 = req1_val1;
      alu_val2 = req1_val2;
      alu_cmd  = req1_cmd;
    end
  end

  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_res_d   = rsp0_res_q;
    rsp1_res_d   = rsp1_res_q;
    rsp0_sts_d   = rsp0_sts_q;
    rsp1_sts_d   = rsp1_sts_q;
    status_d     = status_q;
    rr_ptr_d     = rr_ptr_q;
    if (flush) begin
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
    end else begin
      if (gnt0) begin
        rsp0_valid_d = 1'b1;
        rsp0_res_d   = alu_res;
        rsp0_sts_d   = alu_status;
      end else if (rsp0_ready) begin
        rsp0_valid_d = 1'b0;
      end
      if (gnt1) begin
        rsp1_valid_d = 1'b1;
        rsp1_res_d   = alu_res;
        rsp1_sts_d   = alu_status;
      end else if (rsp1_ready) begin
        rsp1_valid_d = 1'b0;
      end
      if ((gnt0 & req0_s) | (gnt1 & req1_s)) begin
        status_d = alu_status;
      end
      // loser of a contended cycle gets priority next time
      if (both) begin
        rr_ptr_d = gnt0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_res_q   <= '0;
      rsp1_res_q   <= '0;
      rsp0_sts_q   <= '0;
      rsp1_sts_q   <= '0;
      status_q     <= STATUS_RST;
      rr_ptr_q     <= 1'b0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp1_res_q   <= rsp1_res_d;
      rsp0_sts_q   <= rsp0_sts_d;
      rsp1_sts_q   <= rsp1_sts_d;
      status_q     <= status_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp0_res     = rsp0_res_q;
  assign rsp1_res     = rsp1_res_q;
  assign rsp0_status  = rsp0_sts_q;
  assign rsp1_status  = rsp1_sts_q;
  assign alu_carry_in = status_q[2];
  assign status_reg   = status_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: external ALU model, scoreboard model of the
// arbiter/buffers/NZCV, directed vectors with literal expectations.
module tb_alu_share_ctrl;

  localparam logic [3:0] C_ADD = 4'd0;
  localparam logic [3:0] C_ADC = 4'd1;
  localparam logic [3:0] C_SUB = 4'd2;
  localparam logic [3:0] C_AND = 4'd4;
  localparam logic [3:0] C_ORR = 4'd5;
  localparam logic [3:0] C_EOR = 4'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  rq_v = '0;
  logic [31:0] rq_v1 [2];
  logic [31:0] rq_v2 [2];
  logic [3:0]  rq_cmd [2];
  logic [1:0]  rq_s = '0;
  logic [1:0]  rs_rdy = '0;

  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_res, rsp1_res;
  logic [3:0]  rsp0_status, rsp1_status;
  logic [31:0] alu_val1, alu_val2, alu_res;
  logic [3:0]  alu_cmd, alu_status, status_reg;
  logic        alu_carry_in;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.RR_EN(1'b1), .STATUS_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(rq_v[0]), .req0_ready(req0_ready),
    .req0_val1(rq_v1[0]), .req0_val2(rq_v2[0]),
    .req0_cmd(rq_cmd[0]), .req0_s(rq_s[0]),
    .req1_valid(rq_v[1]), .req1_ready(req1_ready),
    .req1_val1(rq_v1[1]), .req1_val2(rq_v2[1]),
    .req1_cmd(rq_cmd[1]), .req1_s(rq_s[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rs_rdy[0]),
    .rsp0_res(rsp0_res), .rsp0_status(rsp0_status),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rs_rdy[1]),
    .rsp1_res(rsp1_res), .rsp1_status(rsp1_status),
    .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_cmd(alu_cmd), .alu_carry_in(alu_carry_in),
    .alu_res(alu_res), .alu_status(alu_status),
    .status_reg(status_reg)
  );

  // ALU behaviour: returns {Z,C,N,V, result}
  function automatic logic [35:0] alu_fn(input logic [3:0] cmd,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic cin);
    logic [32:0] t;
    logic [31:0] r;
    logic c, v;
    c = cin;
    v = 1'b0;
    case (cmd)
      4'd0: t = {1'b0, a} + {1'b0, b};
      4'd1: t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      4'd2: t = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'd3: t = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
      4'd4: t = {1'b0, a & b};
      4'd5: t = {1'b0, a | b};
      4'd6: t = {1'b0, a ^ b};
      default: t = {1'b0, b};
    endcase
    r = t[31:0];
    if (cmd <= 4'd3) begin
      c = t[32];
      if (cmd <= 4'd1) v = (a[31] == b[31]) && (r[31] != a[31]);
      else v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return {r == 32'd0, c, r[31], v, r};
  endfunction

  always_comb {alu_status, alu_res} = alu_fn(alu_cmd, alu_val1, alu_val2, alu_carry_in);

  // ---- reference model ----
  logic [1:0]  m_bv;
  logic [31:0] m_res [2];
  logic [3:0]  m_sts [2];
  logic [3:0]  m_sreg;
  logic        m_ptr;
  logic [1:0]  m_elig, m_gnt;
  logic [35:0] m_o [2];

  always_comb begin
    m_elig[0] = rq_v[0] && (!m_bv[0] || rs_rdy[0]);
    m_elig[1] = rq_v[1] && (!m_bv[1] || rs_rdy[1]);
    m_gnt = 2'b00;
    if (rst_n && !flush) begin
      if (m_elig == 2'b11) m_gnt = m_ptr ? 2'b10 : 2'b01;
      else m_gnt = m_elig;
    end
    for (int n = 0; n < 2; n++)
      m_o[n] = alu_fn(rq_cmd[n], rq_v1[n], rq_v2[n], m_sreg[2]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bv <= 2'b00;
      m_res[0] <= '0;
      m_res[1] <= '0;
      m_sts[0] <= '0;
      m_sts[1] <= '0;
      m_sreg <= 4'b0000;
      m_ptr <= 1'b0;
    end else if (flush) begin
      m_bv <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (m_gnt[n]) begin
          m_bv[n] <= 1'b1;
          m_res[n] <= m_o[n][31:0];
          m_sts[n] <= m_o[n][35:32];
          if (rq_s[n]) m_sreg <= m_o[n][35:32];
        end else if (rs_rdy[n]) begin
          m_bv[n] <= 1'b0;
        end
      end
      if (m_elig == 2'b11) m_ptr <= ~m_gnt[1];
    end
  end

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle compare against the model
  always @(negedge clk) begin
    int sel;
    sel = m_gnt[1] ? 1 : 0;
    chk("m_req0_ready", {35'd0, req0_ready}, {35'd0, m_gnt[0]});
    chk("m_req1_ready", {35'd0, req1_ready}, {35'd0, m_gnt[1]});
    chk("m_rsp0_valid", {35'd0, rsp0_valid}, {35'd0, m_bv[0]});
    chk("m_rsp1_valid", {35'd0, rsp1_valid}, {35'd0, m_bv[1]});
    chk("m_rsp0", {rsp0_status, rsp0_res}, {m_sts[0], m_res[0]});
    chk("m_rsp1", {rsp1_status, rsp1_res}, {m_sts[1], m_res[1]});
    chk("m_status_reg", {32'd0, status_reg}, {32'd0, m_sreg});
    chk("m_carry_in", {35'd0, alu_carry_in}, {35'd0, m_sreg[2]});
    chk("m_alu_drive", {alu_cmd, alu_val1}, {rq_cmd[sel], rq_v1[sel]});
    chk("m_alu_val2", {4'd0, alu_val2}, {4'd0, rq_v2[sel]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int n, input logic [3:0] cmd, input logic [31:0] a,
                      input logic [31:0] b, input logic s);
    rq_cmd[n] = cmd;
    rq_v1[n] = a;
    rq_v2[n] = b;
    rq_s[n] = s;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [1:0] gseq [4];
  logic [1:0] gl;

  initial begin
    setp(0, C_ADD, 0, 0, 1'b0);
    setp(1, C_ADD, 0, 0, 1'b0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #2 rq_v = 2'b11;
    @(negedge clk);
    chk("rst_req0_ready", {35'd0, req0_ready}, 36'd0);
    chk("rst_rsp_valid", {34'd0, rsp1_valid, rsp0_valid}, 36'd0);
    chk("rst_status", {32'd0, status_reg}, 36'd0);
    rq_v = 2'b00;
    #3 rst_n = 1'b1;

    // ADD FFFFFFFF+1 with flag update
    tick();
    setp(0, C_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    rq_v = 2'b01;
    @(negedge clk);
    chk("add_ready", {35'd0, req0_ready}, 36'd1);
    tick();
    rq_v = 2'b00;
    @(negedge clk);
    chk("add_valid", {35'd0, rsp0_valid}, 36'd1);
    chk("add_rsp", {rsp0_status, rsp0_res}, {4'b1100, 32'h0});
    chk("add_status", {32'd0, status_reg}, {32'd0, 4'b1100});

    // ADC on port 1 consumes the carry
    tick();
    rs_rdy = 2'b01;
    setp(1, C_ADC, 32'h0, 32'h0, 1'b0);
    rq_v = 2'b10;
    @(negedge clk);
    chk("adc_cin", {35'd0, alu_carry_in}, 36'd1);
    tick();
    rq_v = 2'b00;
    @(negedge clk);
    chk("adc_res", {4'd0, rsp1_res}, 36'd1);
    chk("adc_status", {32'd0, status_reg}, {32'd0, 4'b1100});
    chk("adc_rsp0_drained", {35'd0, rsp0_valid}, 36'd0);

    // contention, round robin
    tick();
    rs_rdy = 2'b11;
    setp(0, C_ADD, 32'd5, 32'd7, 1'b0);
    setp(1, C_SUB, 32'd10, 32'd3, 1'b1);
    rq_v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gseq[i] = {req1_ready, req0_ready};
      tick();
    end
    chk("rr_g0", {34'd0, gseq[0]}, 36'b01);
    chk("rr_g1", {34'd0, gseq[1]}, 36'b10);
    chk("rr_g2", {34'd0, gseq[2]}, 36'b01);
    chk("rr_g3", {34'd0, gseq[3]}, 36'b10);
    rq_v = 2'b00;
    rs_rdy = 2'b00;
    @(negedge clk);
    chk("rr_rsp1", {rsp1_valid, rsp1_status, rsp1_res}, {1'b1, 4'b0100, 32'd7});
    chk("rr_rsp0_valid", {35'd0, rsp0_valid}, 36'd0);
    chk("rr_status", {32'd0, status_reg}, {32'd0, 4'b0100});

    // backpressure on port 0
    tick();
    setp(0, C_ORR, 32'h00FF, 32'h0F00, 1'b0);
    rq_v = 2'b01;
    @(negedge clk);
    chk("bp_fill_ready", {35'd0, req0_ready}, 36'd1);
    tick();
    setp(0, C_AND, 32'hF0F0, 32'hFF00, 1'b0);
    setp(1, C_EOR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
    rq_v = 2'b11;
    rs_rdy = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req0_ready", {35'd0, req0_ready}, 36'd0);
      chk("bp_req1_ready", {35'd0, req1_ready}, 36'd1);
      chk("bp_rsp0_held", {rsp0_valid, rsp0_res}, {1'b1, 32'h0FFF});
      tick();
    end
    rs_rdy = 2'b11;
    @(negedge clk);
    chk("bp_reload_ready", {35'd0, req0_ready}, 36'd1);
    tick();
    @(negedge clk);
    chk("bp_reload_rsp0", {rsp0_valid, rsp0_res}, {1'b1, 32'hF000});

    // flush with both buffers full and both requests valid
    rs_rdy = 2'b00;
    rq_v = 2'b10;
    setp(1, C_EOR, 32'h1, 32'h2, 1'b0);
    tick();
    @(negedge clk);
    chk("fl_full", {34'd0, rsp1_valid, rsp0_valid}, 36'b11);
    setp(1, C_EOR, 32'h5, 32'h5, 1'b1);
    setp(0, C_SUB, 32'h0, 32'h1, 1'b1);
    rq_v = 2'b11;
    rs_rdy = 2'b11;
    flush = 1'b1;
    #1;
    chk("fl_no_grant", {34'd0, req1_ready, req0_ready}, 36'd0);
    tick();
    flush = 1'b0;
    rq_v = 2'b00;
    @(negedge clk);
    chk("fl_cleared", {34'd0, rsp1_valid, rsp0_valid}, 36'd0);
    chk("fl_status", {32'd0, status_reg}, {32'd0, 4'b0100});

    // randomised traffic, fields held while pending
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      gl = m_gnt;
      tick();
      for (int n = 0; n < 2; n++) begin
        if (!(rq_v[n] && !gl[n])) begin
          rq_v[n] = ($urandom_range(0, 3) != 0);
          setp(n, 4'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
      end
      rs_rdy = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 15) == 0);
    end
    flush = 1'b0;

    // async reset mid-burst
    setp(0, C_SUB, 32'h0, 32'h1, 1'b1);
    setp(1, C_ADD, 32'h3, 32'h4, 1'b0);
    rq_v = 2'b11;
    rs_rdy = 2'b11;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {34'd0, rsp1_valid, rsp0_valid}, 36'd0);
    chk("ar_rsp0", {rsp0_status, rsp0_res}, 36'd0);
    chk("ar_rsp1", {rsp1_status, rsp1_res}, 36'd0);
    chk("ar_status", {32'd0, status_reg}, 36'd0);
    chk("ar_ready", {34'd0, req1_ready, req0_ready}, 36'd0);
    tick();
    #2 rst_n = 1'b1;
    repeat (4) tick();
    rq_v = 2'b00;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
